// File: rtl/winograd_input_transform.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : winograd_input_transform (with helper winograd_bt_row)           |
// | Brief   : Two-stage Winograd input transform V = B^T d B, F(4,3) / F(2,3). |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

// Applies B^T to one 6-element vector using shifts and adds only.
module winograd_bt_row #(
  parameter int W = 20
) (
  input  logic              mode,
  input  logic [0:5][W-1:0] x,
  output logic [0:5][W-1:0] y
);

  logic signed [W-1:0] w_x [0:5];

  for (genvar k = 0; k < 6; k++) begin : g_x
    assign w_x[k] = x[k];
  end

  // W is chosen by the caller so every partial sum below is exact.
  always_comb begin
    y = '0;
    if (!mode) begin
      y[0] = (w_x[0] <<< 2) - (w_x[2] <<< 2) - w_x[2] + w_x[4];
      y[1] = w_x[3] + w_x[4] - ((w_x[1] + w_x[2]) <<< 2);
      y[2] = w_x[4] - w_x[3] + ((w_x[1] - w_x[2]) <<< 2);
      y[3] = w_x[4] - w_x[2] + ((w_x[3] - w_x[1]) <<< 1);
      y[4] = w_x[4] - w_x[2] + ((w_x[1] - w_x[3]) <<< 1);
      y[5] = (w_x[1] <<< 2) - (w_x[3] <<< 2) - w_x[3] + w_x[5];
    end else begin
      y[0] = w_x[0] - w_x[2];
      y[1] = w_x[1] + w_x[2];
      y[2] = w_x[2] - w_x[1];
      y[3] = w_x[1] - w_x[3];
    end
  end

endmodule

module winograd_input_transform #(
  parameter  int DATA_W = 16,
  localparam int OUT_W  = DATA_W + 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [0:5][0:5][DATA_W-1:0]   tile_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_mode,
  output logic [0:5][0:5][OUT_W-1:0]    tile_out,
  output logic [15:0]                   tile_count
);

  localparam int c_T_W = DATA_W + 4;

  logic                              r_s1_valid;
  logic                              r_s1_mode;
  logic [0:5][0:5][c_T_W-1:0]        r_t;
  logic                              r_out_valid;
  logic                              r_out_mode;
  logic [0:5][0:5][OUT_W-1:0]        r_tile_out;
  logic [15:0]                       r_tile_count;

  logic                              w_s1_load;
  logic                              w_s2_load;
  logic [0:5][0:5][c_T_W-1:0]        w_t_next;
  logic [0:5][0:5][OUT_W-1:0]        w_v_next;

  assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
  // Held low during reset so nothing is offered a handshake before release.
  assign in_ready  = rst_n && !flush && (!r_s1_valid || w_s2_load);
  assign w_s1_load = in_valid && in_ready;

  // Stage 1: T = B^T d, column by column.
  for (genvar j = 0; j < 6; j++) begin : g_s1_col
    logic [0:5][c_T_W-1:0] w_col_in;
    logic [0:5][c_T_W-1:0] w_col_out;
    for (genvar k = 0; k < 6; k++) begin : g_s1_elem
      assign w_col_in[k]    = {{(c_T_W - DATA_W){tile_in[k][j][DATA_W-1]}}, tile_in[k][j]};
      assign w_t_next[k][j] = w_col_out[k];
    end
    winograd_bt_row #(.W(c_T_W)) u_bt (
      .mode (in_mode),
      .x    (w_col_in),
      .y    (w_col_out)
    );
  end

  // Stage 2: V = T B, i.e. B^T applied along each row of T.
  for (genvar i = 0; i < 6; i++) begin : g_s2_row
    logic [0:5][OUT_W-1:0] w_row_in;
    for (genvar k = 0; k < 6; k++) begin : g_s2_elem
      assign w_row_in[k] = {{(OUT_W - c_T_W){r_t[i][k][c_T_W-1]}}, r_t[i][k]};
    end
    winograd_bt_row #(.W(OUT_W)) u_bt (
      .mode (r_s1_mode),
      .x    (w_row_in),
      .y    (w_v_next[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_mode    <= 1'b0;
      r_t          <= '0;
      r_out_valid  <= 1'b0;
      r_out_mode   <= 1'b0;
      r_tile_out   <= '0;
      r_tile_count <= '0;
    end else begin
      if (flush) begin
        r_s1_valid  <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        if (w_s1_load) begin
          r_s1_valid <= 1'b1;
        end else if (w_s2_load) begin
          r_s1_valid <= 1'b0;
        end
        if (w_s2_load) begin
          r_out_valid <= 1'b1;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (r_out_valid && out_ready) begin
          r_tile_count <= r_tile_count + 16'd1;
        end
      end
      if (w_s1_load) begin
        r_s1_mode <= in_mode;
        r_t       <= w_t_next;
      end
      if (w_s2_load && !flush) begin
        r_out_mode <= r_s1_mode;
        r_tile_out <= w_v_next;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_mode   = r_out_mode;
  assign tile_out   = r_tile_out;
  assign tile_count = r_tile_count;

endmodule
`default_nettype wire

// File: tb/tb_winograd_input_transform.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_winograd_input_transform                                      |
// | Brief   : Directed self-checking bench for winograd_input_transform.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_winograd_input_transform;

  localparam int DW = 16;
  localparam int OW = 23;
  typedef logic [0:5][0:5][DW-1:0] tin_t;
  typedef logic [0:5][0:5][OW-1:0] tout_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_mode   = 1'b0;
  logic        out_ready = 1'b0;
  tin_t        tile_in   = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_mode;
  tout_t       tile_out;
  logic [15:0] tile_count;

  int n_checks = 0;
  int n_pass   = 0;

  int bt0 [0:5][0:5] = '{'{4, 0, -5, 0, 1, 0}, '{0, -4, -4, 1, 1, 0}, '{0, 4, -4, -1, 1, 0},
                         '{0, -2, -1, 2, 1, 0}, '{0, 2, -1, -2, 1, 0}, '{0, 4, 0, -5, 0, 1}};
  int bt1 [0:5][0:5] = '{'{1, 0, -1, 0, 0, 0}, '{0, 1, 1, 0, 0, 0}, '{0, -1, 1, 0, 0, 0},
                         '{0, 1, 0, -1, 0, 0}, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}};

  always #5 clk = ~clk;

  winograd_input_transform #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .tile_in    (tile_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mode   (out_mode),
    .tile_out   (tile_out),
    .tile_count (tile_count)
  );

  // Reference: plain integer matrix products with the B^T tables above.
  function automatic tout_t ref_v(input tin_t d, input logic m);
    int    t [0:5][0:5];
    int    acc;
    int    c;
    tout_t v;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        acc = 0;
        for (int k = 0; k < 6; k++) begin
          c = m ? bt1[i][k] : bt0[i][k];
          acc += c * int'($signed(d[k][j]));
        end
        t[i][j] = acc;
      end
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        acc = 0;
        for (int k = 0; k < 6; k++) begin
          c = m ? bt1[j][k] : bt0[j][k];
          acc += c * t[i][k];
        end
        v[i][j] = acc[OW-1:0];
      end
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || out_mode !== 1'b0) $display("FAIL reset_out_flags: got v=%0b m=%0b want 0 0", out_valid, out_mode); else n_pass++;
    n_checks++; if (tile_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", tile_count); else n_pass++;
    n_checks++; if (tile_out !== '0) $display("FAIL reset_tile_out: got %h want 0", tile_out); else n_pass++;
    tick; tick;
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_impulse;
    tin_t d; tout_t e;
    d = '0; d[0][0] = 16'd1;
    e = '0; e[0][0] = 23'd16;
    out_ready = 1'b1; in_mode = 1'b0; tile_in = d; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_mode !== 1'b0) $display("FAIL impulse_valid: got v=%0b m=%0b want 1 0", out_valid, out_mode); else n_pass++;
    n_checks++; if (tile_out !== e) $display("FAIL impulse_tile: got %h want %h", tile_out, e); else n_pass++;
    tick;
    n_checks++; if (tile_count !== 16'd1 || out_valid !== 1'b0) $display("FAIL impulse_count: got c=%0d v=%0b want 1 0", tile_count, out_valid); else n_pass++;
  endtask

  task automatic test_ones;
    tin_t d; tout_t ea, eb;
    for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) d[r][c] = 16'd1;
    ea = '0; ea[1][1] = 23'd36;
    eb = '0; eb[1][1] = 23'd4;
    out_ready = 1'b1; tile_in = d; in_mode = 1'b0; in_valid = 1'b1;
    tick;
    in_mode = 1'b1;
    tick;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_mode !== 1'b0 || tile_out !== ea) $display("FAIL ones_mode0: got v=%0b m=%0b %h want %h", out_valid, out_mode, tile_out, ea); else n_pass++;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_mode !== 1'b1 || tile_out !== eb) $display("FAIL ones_mode1: got v=%0b m=%0b %h want %h", out_valid, out_mode, tile_out, eb); else n_pass++;
    tick;
    n_checks++; if (tile_count !== 16'd3 || out_valid !== 1'b0) $display("FAIL ones_count: got c=%0d v=%0b want 3 0", tile_count, out_valid); else n_pass++;
  endtask

  task automatic test_range;
    tin_t d; int p;
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 6; j++) begin
        p = bt0[0][k] * bt0[0][j];
        d[k][j] = (p > 0) ? 16'h7fff : ((p < 0) ? 16'h8000 : 16'h0000);
      end
    out_ready = 1'b1; tile_in = d; in_mode = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    n_checks++; if (tile_out[0][0] !== 23'd3276750) $display("FAIL range_v00: got %0d want 3276750", tile_out[0][0]); else n_pass++;
    n_checks++; if (tile_out !== ref_v(d, 1'b0)) $display("FAIL range_tile: got %h want %h", tile_out, ref_v(d, 1'b0)); else n_pass++;
    tick;
  endtask

  task automatic test_mixed;
    tin_t da, db;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        da[r][c] = 16'(r * 1000 - c * 3001 + 7);
        db[r][c] = 16'(-(r + 1) * (c + 2) * 517);
      end
    out_ready = 1'b1; tile_in = da; in_mode = 1'b0; in_valid = 1'b1;
    tick;
    tile_in = db; in_mode = 1'b1;
    tick;
    in_valid = 1'b0;
    n_checks++; if (out_mode !== 1'b0 || tile_out !== ref_v(da, 1'b0)) $display("FAIL mixed_mode0: got m=%0b %h want %h", out_mode, tile_out, ref_v(da, 1'b0)); else n_pass++;
    tick;
    n_checks++; if (out_mode !== 1'b1 || tile_out !== ref_v(db, 1'b1)) $display("FAIL mixed_mode1: got m=%0b %h want %h", out_mode, tile_out, ref_v(db, 1'b1)); else n_pass++;
    tick;
  endtask

  task automatic test_back_to_back;
    tin_t tl [4];
    logic md [4];
    int   sent, recv;
    tout_t e;
    for (int n = 0; n < 4; n++) begin
      md[n] = n[0];
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) tl[n][r][c] = 16'((n + 1) * 97 + r * 13 - c * 29);
    end
    do_reset;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        tile_in = tl[sent]; in_mode = md[sent];
      end
      #1;
      if (cyc == 2) begin
        n_checks++; if (in_ready !== 1'b0 || sent != 2) $display("FAIL b2b_stall_ready: got r=%0b sent=%0d want 0 2", in_ready, sent); else n_pass++;
      end
      if (out_valid) begin
        if (recv < 4) begin
          e = ref_v(tl[recv], md[recv]);
          n_checks++; if (tile_out !== e || out_mode !== md[recv]) $display("FAIL b2b_tile%0d: got m=%0b %h want %h", recv, out_mode, tile_out, e); else n_pass++;
          if (out_ready) recv++;
        end else begin
          n_checks++; $display("FAIL b2b_extra: got out_valid=1 want 0");
        end
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (recv != 4 || sent != 4) $display("FAIL b2b_totals: got sent=%0d recv=%0d want 4 4", sent, recv); else n_pass++;
    n_checks++; if (tile_count !== 16'd4) $display("FAIL b2b_count: got %0d want 4", tile_count); else n_pass++;
  endtask

  task automatic test_flush;
    int seen;
    out_ready = 1'b0; in_mode = 1'b0; in_valid = 1'b1;
    tile_in = '0; tile_in[0][0] = 16'd5;
    tick;
    tile_in[0][0] = 16'd9;
    tick;
    flush = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %0b want 0", in_ready); else n_pass++;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || tile_count !== 16'd4) $display("FAIL flush_state: got v=%0b c=%0d want 0 4", out_valid, tile_count); else n_pass++;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_release_ready: got %0b want 1", in_ready); else n_pass++;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (out_valid) seen++;
    end
    n_checks++; if (seen != 0 || tile_count !== 16'd4) $display("FAIL flush_stale: got seen=%0d c=%0d want 0 4", seen, tile_count); else n_pass++;
  endtask

  task automatic test_reset_midflight;
    int seen;
    out_ready = 1'b0; in_mode = 1'b1; in_valid = 1'b1;
    tile_in = '0; tile_in[1][2] = 16'd3;
    tick;
    tile_in[2][1] = 16'd7;
    tick;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || tile_count !== 16'd0 || in_ready !== 1'b0) $display("FAIL midreset_state: got v=%0b c=%0d r=%0b want 0 0 0", out_valid, tile_count, in_ready); else n_pass++;
    n_checks++; if (tile_out !== '0) $display("FAIL midreset_tile: got %h want 0", tile_out); else n_pass++;
    tick; tick;
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (out_valid) seen++;
    end
    n_checks++; if (seen != 0 || tile_count !== 16'd0) $display("FAIL midreset_stale: got seen=%0d c=%0d want 0 0", seen, tile_count); else n_pass++;
  endtask

  task automatic test_wrap;
    do_reset;
    out_ready = 1'b1; tile_in = '0; in_mode = 1'b0; in_valid = 1'b1;
    repeat (65535) tick;
    in_valid = 1'b0;
    repeat (3) tick;
    n_checks++; if (tile_count !== 16'd65535 || out_valid !== 1'b0) $display("FAIL wrap_preload: got c=%0d v=%0b want 65535 0", tile_count, out_valid); else n_pass++;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    n_checks++; if (tile_count !== 16'd0) $display("FAIL wrap_rollover: got %0d want 0", tile_count); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_impulse;
    test_ones;
    test_range;
    test_mixed;
    test_back_to_back;
    test_flush;
    test_reset_midflight;
    test_wrap;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
